// File: rtl/segment_sequencer_if.sv
// rtl/segment_sequencer_if.sv - requester/picker bus between a requester and the segment sequencer
interface segment_sequencer_if;
  logic       Start;
  logic       Abort;
  logic [3:0] Din;
  logic       Din_valid;
  logic       Din_ready;
  logic       L0;
  logic       L1;
  logic       L2;
  logic       L3;
  logic       A0;
  logic       A1;
  logic       E;
  logic       Busy;
  logic       Done;
  logic [2:0] Seg_cnt;

  modport master (
    output Start, Abort, Din, Din_valid,
    input  Din_ready, L0, L1, L2, L3, A0, A1, E, Busy, Done, Seg_cnt
  );

  modport slave (
    input  Start, Abort, Din, Din_valid,
    output Din_ready, L0, L1, L2, L3, A0, A1, E, Busy, Done, Seg_cnt
  );
endinterface

// File: rtl/segment_sequencer.sv
// rtl/segment_sequencer.sv - loads four nibbles into segments 0..3 of a picker with a setup/strobe/hold write
module segment_sequencer (
  input  logic               Clk,
  input  logic               Rst,
  segment_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_l;
  logic [1:0] r_a;
  logic       r_e;
  logic       r_din_ready;
  logic       r_busy;
  logic       r_done;
  logic [2:0] r_seg_cnt;

  logic       w_abort;
  logic       w_start;
  logic       w_hs;

  // Abort only matters outside IDLE, but it still vetoes a Start sampled in IDLE.
  assign w_abort = bus.Abort && (r_state != S_IDLE);
  assign w_start = (r_state == S_IDLE) && bus.Start && !bus.Abort;
  assign w_hs    = (r_state == S_ACCEPT) && bus.Din_valid && r_din_ready && !bus.Abort;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_ACCEPT;
      S_ACCEPT: if (w_hs) w_next = S_SETUP;
      S_SETUP:  w_next = S_STROBE;
      S_STROBE: w_next = S_HOLD;
      S_HOLD:   w_next = (r_seg_cnt == 3'd3) ? S_DONE : S_ACCEPT;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Every output flop is loaded from the next state so the pins line up with the state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_l         <= 4'd0;
      r_a         <= 2'd0;
      r_e         <= 1'b0;
      r_din_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_seg_cnt   <= 3'd0;
    end else begin
      r_state     <= w_next;
      r_e         <= (w_next == S_STROBE);
      r_din_ready <= (w_next == S_ACCEPT);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      if (w_hs) begin
        r_l <= bus.Din;
        r_a <= r_seg_cnt[1:0];
      end
      if (w_start) begin
        r_seg_cnt <= 3'd0;
      end else if ((r_state == S_HOLD) && !w_abort) begin
        r_seg_cnt <= r_seg_cnt + 3'd1;
      end
    end
  end

  assign bus.L0        = r_l[0];
  assign bus.L1        = r_l[1];
  assign bus.L2        = r_l[2];
  assign bus.L3        = r_l[3];
  assign bus.A0        = r_a[0];
  assign bus.A1        = r_a[1];
  assign bus.E         = r_e;
  assign bus.Din_ready = r_din_ready;
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.Seg_cnt   = r_seg_cnt;
endmodule
